// File: rtl/sha_pkg.sv
// Shared SHA-256 constants, round functions and control-state encoding.
// Imported by sha_round and sha_core_param.
package sha_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2
    } state_e;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(logic [31:0] e, logic [31:0] f,
                                       logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(logic [31:0] a, logic [31:0] b,
                                        logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Word-wise (8 x 32-bit, wrap-around) sum of two chaining values.
    function automatic logic [255:0] add8(logic [255:0] x, logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

endpackage

// File: rtl/sha_round.sv
// One combinational SHA-256 round: a..h + Wt + Kt -> next a..h.
// Ports: state_in/state_out {a..h} with a in [255:224]; w, k round inputs.
module sha_round
    import sha_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;

    assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
    assign t2 = bsig0(a) + maj(a, b, c);

    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha_core_param.sv
// SHA-256 compression engine, ROUNDS_PER_CYCLE rounds per clock, optional dSHA256.
// Ports: clk, rst (async active-low), start/dbl/start_state/input_message in; busy/done/result out.
module sha_core_param
    import sha_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dbl,
    input  logic [255:0] start_state,
    input  logic [511:0] input_message,
    output logic         busy,
    output logic         done,
    output logic [255:0] result
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8 || R == 16)) begin : g_bad_r
        $error("sha_core_param: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_e       state;
    logic [6:0]   cnt;
    logic         pass;
    logic         dbl_q;
    logic [255:0] h_q;
    logic [255:0] work;
    logic [31:0]  w [16];

    logic [31:0]  ext [16+R];
    logic [255:0] chain [R+1];
    logic [255:0] digest;
    logic [6:0]   cnt_nxt;

    // Schedule window extended by R words: ext[0..R-1] feed this cycle's
    // rounds, ext[R..R+15] become the next window.
    always_comb begin
        for (int j = 0; j < 16; j++)
            ext[j] = w[j];
        for (int j = 16; j < 16 + R; j++)
            ext[j] = ssig1(ext[j-2]) + ext[j-7] + ssig0(ext[j-15]) + ext[j-16];
    end

    assign chain[0] = work;

    for (genvar i = 0; i < R; i++) begin : g_rnd
        sha_round u_rnd (
            .state_in  (chain[i]),
            .w         (ext[i]),
            .k         (K[cnt[5:0] + 6'(i)]),
            .state_out (chain[i+1])
        );
    end

    assign digest  = add8(work, h_q);
    assign cnt_nxt = cnt + 7'(R);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            pass   <= 1'b0;
            dbl_q  <= 1'b0;
            h_q    <= '0;
            work   <= '0;
            for (int i = 0; i < 16; i++)
                w[i] <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        h_q   <= start_state;
                        work  <= start_state;
                        dbl_q <= dbl;
                        for (int i = 0; i < 16; i++)
                            w[i] <= input_message[511-32*i -: 32];
                        cnt   <= '0;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    work <= chain[R];
                    for (int i = 0; i < 16; i++)
                        w[i] <= ext[i+R];
                    cnt <= cnt_nxt;
                    if (cnt_nxt == 7'd64)
                        state <= ST_FINAL;
                end
                ST_FINAL: begin
                    if (dbl_q && !pass) begin
                        // Second pass hashes the 32-byte digest as one padded block.
                        h_q  <= IV;
                        work <= IV;
                        for (int i = 0; i < 8; i++)
                            w[i] <= digest[255-32*i -: 32];
                        w[8] <= 32'h80000000;
                        for (int i = 9; i < 15; i++)
                            w[i] <= '0;
                        w[15] <= 32'd256;
                        cnt   <= '0;
                        pass  <= 1'b1;
                        state <= ST_ROUND;
                    end else begin
                        result <= digest;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sha_core_param.md
# sha_core_param

Parametrised SHA-256 compression engine and successor to the single-configuration `sha_core`. It unrolls a configurable number of rounds per clock. It also adds an optional double-hash mode: the first 256-bit digest is padded and compressed again from the standard IV, which is the Bitcoin dSHA256 step. It sits between the work/midstate feeder and the nonce/target comparator, and keeps the start/done handshake and port names of `sha_core`.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: rounds computed per clock. Legal values are 1, 2, 4, 8, 16; elaboration fails otherwise.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only while idle.
- `dbl`  in  1  sampled with `start`. 1 = double-hash mode.
- `start_state`  in  256  chaining value H0..H7, H0 in bits [255:224].
- `input_message`  in  512  one padded block, W0 in bits [511:480].
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle on.
- `result`  out  256  digest. Held until the next `done` or reset.

## Operation
- States: IDLE, ROUND, FINAL.
- **IDLE.** On `start`=1: latch `start_state`, `input_message` and `dbl`. Load a..h from `start_state` and W[0..15] from the message. Clear round counter and pass bit. Go to ROUND.
- **ROUND.** Each edge performs R = `ROUNDS_PER_CYCLE` rounds. It advances the 16-word W window by R (σ0/σ1 schedule) and adds R to the counter. When the counter reaches 64, go to FINAL.
- **FINAL, single pass** (dbl=0, or pass=1): `result` = {a..h} + latched H (per-word modulo 2^32). Pulse `done`. Go to IDLE.
- **FINAL, first pass of double** (dbl=1, pass=0): digest D is not output and `done` stays low. Load H and a..h with the standard IV. Load the message {D, 1'b1, 191'b0, 64'd256}. Set pass=1 and go to ROUND.
- `start` while busy is ignored, with no queueing. Input changes after acceptance have no effect.
- All additions are 32-bit wrap-around. The round counter is 7 bits and compares equal to 64. No R exceeds 64 or misaligns the counter, since R divides 64.

## Timing
- Reset values: `done`=0, `busy`=0, `result`=0; state IDLE, counter 0, pass 0.
- Let N = 64/R. With the accepting edge as E0, single-pass `done` is high after edge E(N+1): 65 cycles at R=1, 5 at R=16.
- Double-pass `done` is high after edge E(2N+2): 130 cycles at R=1.
- `done` is high for exactly one cycle. `busy` falls in the same cycle `done` rises.
- `start` held high continuously: a new job is accepted on the first idle edge after `done`, i.e. the cycle after the `done` cycle.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. A partial digest is never output.

## Structure
- Shared package `sha_pkg`:
  - K[0..63] constant array and IV constant.
  - Functions Σ0, Σ1, σ0, σ1, Ch, Maj.
  - State enum.
- Sub-module `sha_round`: one combinational round, working vars + Wt + Kt -> next working vars. Instantiate R times in a generate chain; message-schedule expansion stays in the top.

## Test plan
- "" (empty, padded), IV, dbl=0, R=1 -> `result` e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; `done` at cycle 65.
- "abc" padded, IV, dbl=0, run for R=1,2,4,8,16 -> `result` ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad in all configurations; `done` at cycle 64/R+1.
- "abc", dbl=1, R=1 -> `result` 4f8b42c2 2dd3729b 519ba6f6 8d2da7cc 5b2d606d 05daed5a d5128cc0 3e6c6358; `done` at cycle 130, no `done` at cycle 65.
- `start` re-pulsed during busy, and inputs changed mid-job -> ignored; original "abc" digest still produced, exactly one `done`.
- `rst` low at cycle 30 of a job -> `busy`/`done`/`result` to 0 at once; a fresh "abc" job after release gives the correct digest.
- `start` held high for 3 jobs -> back-to-back digests with exactly one idle cycle between `done` pulses.
